// File: rtl/apb_mst.sv
// APB initiator: accepts one request at a time and runs one SETUP/ACCESS transfer.
// Optional ACCESS timeout abort is compiled in with `define APB_MST_TIMEOUT_EN.
package types_amba_pkg;
  typedef struct packed {
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic        psel;
    logic        penable;
  } apb_in_type;

  typedef struct packed {
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
  } apb_out_type;
endpackage

module apb_mst #(
  parameter logic [15:0] timeout = 16'd1023
) (
  input  logic                       i_clk,
  input  logic                       i_pwrreset,
  input  logic                       i_req_valid,
  output logic                       o_req_ready,
  input  logic [31:0]                i_req_addr,
  input  logic                       i_req_write,
  input  logic [31:0]                i_req_wdata,
  input  logic [3:0]                 i_req_wstrb,
  output logic                       o_resp_valid,
  output logic [31:0]                o_resp_rdata,
  output logic                       o_resp_err,
  output types_amba_pkg::apb_in_type o_apbi,
  input  types_amba_pkg::apb_out_type i_apbo,
  output logic                       o_busy
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t      state, state_nxt;
  logic        timeout_hit;
  logic [31:0] paddr_r, pwdata_r;
  logic [3:0]  pstrb_r;
  logic        pwrite_r, psel_r, penable_r, resp_valid_r;
  logic [31:0] resp_rdata_r;
  logic        resp_err_r;

`ifdef APB_MST_TIMEOUT_EN
  logic [15:0] tmo_cnt;

  // Counter restarts in SETUP so it reads zero on the first ACCESS cycle.
  always_ff @(posedge i_clk or posedge i_pwrreset) begin
    if (i_pwrreset)
      tmo_cnt <= 16'd0;
    else if (state == SETUP)
      tmo_cnt <= 16'd0;
    else if (state == ACCESS && !i_apbo.pready)
      tmo_cnt <= tmo_cnt + 16'd1;
  end

  assign timeout_hit = (state == ACCESS) && !i_apbo.pready &&
                       (tmo_cnt == timeout - 16'd1);
`else
  logic unused_timeout;
  assign unused_timeout = ^timeout;
  assign timeout_hit    = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_pwrreset) begin
    if (i_pwrreset) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_req_valid) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (i_apbo.pready || timeout_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus and response outputs are registered from the next state so they align with it.
  always_ff @(posedge i_clk or posedge i_pwrreset) begin
    if (i_pwrreset) begin
      psel_r       <= 1'b0;
      penable_r    <= 1'b0;
      paddr_r      <= 32'd0;
      pwdata_r     <= 32'd0;
      pstrb_r      <= 4'd0;
      pwrite_r     <= 1'b0;
      resp_valid_r <= 1'b0;
      resp_rdata_r <= 32'd0;
      resp_err_r   <= 1'b0;
    end else begin
      psel_r       <= (state_nxt == SETUP) || (state_nxt == ACCESS);
      penable_r    <= (state_nxt == ACCESS);
      resp_valid_r <= (state_nxt == RESP);
      if (state == IDLE && i_req_valid) begin
        paddr_r  <= {i_req_addr[31:2], 2'b00};
        pwrite_r <= i_req_write;
        pwdata_r <= i_req_wdata;
        pstrb_r  <= i_req_write ? i_req_wstrb : 4'h0;
      end
      if (state == ACCESS) begin
        if (i_apbo.pready) begin
          resp_rdata_r <= pwrite_r ? 32'd0 : i_apbo.prdata;
          resp_err_r   <= i_apbo.pslverr;
        end else if (timeout_hit) begin
          resp_rdata_r <= 32'hFFFF_FFFF;
          resp_err_r   <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    o_apbi         = '0;
    o_apbi.paddr   = paddr_r;
    o_apbi.pwrite  = pwrite_r;
    o_apbi.pwdata  = pwdata_r;
    o_apbi.pstrb   = pstrb_r;
    o_apbi.pprot   = 3'b000;
    o_apbi.psel    = psel_r;
    o_apbi.penable = penable_r;
    o_req_ready    = (state == IDLE);
    o_busy         = (state != IDLE);
    o_resp_valid   = resp_valid_r;
    o_resp_rdata   = resp_rdata_r;
    o_resp_err     = resp_err_r;
  end

endmodule

// File: tb/tb_apb_mst.sv
// Directed bench for apb_mst with a responder model and a response scoreboard.
module tb_apb_mst;
  import types_amba_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid, write;
  logic [31:0] addr, wdata;
  logic [3:0]  wstrb;
  logic        req_ready, resp_valid, resp_err, busy;
  logic [31:0] resp_rdata;
  apb_in_type  apbi;
  apb_out_type apbo;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  int          wait_req = 0;
  logic        stuck = 1'b0;
  logic        err_req = 1'b0;
  logic [31:0] rd_val = 32'd0;
  int          acc = 0;
  int          pen_cnt = 0;
  int          resp_cnt = 0;

  always #5 clk = ~clk;

  apb_mst #(.timeout(16'd4)) dut (
    .i_clk        (clk),
    .i_pwrreset   (rst),
    .i_req_valid  (valid),
    .o_req_ready  (req_ready),
    .i_req_addr   (addr),
    .i_req_write  (write),
    .i_req_wdata  (wdata),
    .i_req_wstrb  (wstrb),
    .o_resp_valid (resp_valid),
    .o_resp_rdata (resp_rdata),
    .o_resp_err   (resp_err),
    .o_apbi       (apbi),
    .i_apbo       (apbo),
    .o_busy       (busy)
  );

  // Responder: counts ACCESS cycles and raises pready after wait_req of them.
  always @(posedge clk or posedge rst) begin
    if (rst) acc <= 0;
    else if (apbi.psel && apbi.penable) acc <= acc + 1;
    else acc <= 0;
  end

  always_comb begin
    apbo         = '0;
    apbo.pready  = apbi.psel && apbi.penable && !stuck && (acc >= wait_req);
    apbo.prdata  = rd_val ^ apbi.paddr;
    apbo.pslverr = err_req;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (apbi.penable) pen_cnt++;
    if (resp_valid) begin
      resp_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_resp", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("resp_rdata", resp_rdata, mon_e.rdata);
        check("resp_err", {31'd0, resp_err}, {31'd0, mon_e.err});
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s);
    addr = a; write = w; wdata = d; wstrb = s; valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic wait_resp(input int budget);
    int n = 0;
    while (!resp_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("resp_arrived", {31'd0, resp_valid}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, last, accepts, r0;
    rst = 1'b1; valid = 1'b0; write = 1'b0; addr = '0; wdata = '0; wstrb = '0;
    repeat (2) @(negedge clk);
    check("rst_psel", {31'd0, apbi.psel}, 32'd0);
    check("rst_penable", {31'd0, apbi.penable}, 32'd0);
    check("rst_paddr", apbi.paddr, 32'd0);
    check("rst_pwdata", apbi.pwdata, 32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", {31'd0, req_ready}, 32'd1);

    // Zero-wait read with unaligned address
    rd_val = 32'hDEAD_BEEF ^ 32'h1000_0004;
    sb.push_back('{32'hDEAD_BEEF, 1'b0});
    send(32'h1000_0007, 1'b0, 32'h1111_1111, 4'hF);
    check("rd_setup_psel", {31'd0, apbi.psel}, 32'd1);
    check("rd_setup_penable", {31'd0, apbi.penable}, 32'd0);
    check("rd_paddr", apbi.paddr, 32'h1000_0004);
    check("rd_pstrb", {28'd0, apbi.pstrb}, 32'd0);
    check("rd_pprot", {29'd0, apbi.pprot}, 32'd0);
    check("rd_ready_busy", {30'd0, req_ready, busy}, 32'd1);
    @(negedge clk);
    check("rd_access", {30'd0, apbi.psel, apbi.penable}, 32'd3);
    check("rd_access_resp", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    check("rd_resp_n3", {29'd0, resp_valid, apbi.psel, apbi.penable}, 32'd4);
    @(negedge clk);
    check("rd_idle", {30'd0, req_ready, busy}, 32'd2);
    check("rd_hold", resp_rdata, 32'hDEAD_BEEF);

    // Write with 5 wait states and slave error
    wait_req = 5; err_req = 1'b1; pen_cnt = 0;
    sb.push_back('{32'd0, 1'b1});
    send(32'h2000_0010, 1'b1, 32'h1234_5678, 4'hF);
    check("wr_pwdata", apbi.pwdata, 32'h1234_5678);
    check("wr_pstrb", {28'd0, apbi.pstrb}, 32'hF);
    check("wr_pwrite", {31'd0, apbi.pwrite}, 32'd1);
    wait_resp(20);
    check("wr_penable_cycles", pen_cnt, 32'd6);
    repeat (3) @(negedge clk);
    check("wr_hold_rdata", resp_rdata, 32'd0);
    check("wr_hold_err", {31'd0, resp_err}, 32'd1);
    wait_req = 0; err_req = 1'b0;

    // Back-to-back reads with valid held high
    rd_val = 32'hA5A5_0000;
    write = 1'b0; addr = 32'h3000_0000; valid = 1'b1;
    cyc = 0; last = -1; accepts = 0; r0 = resp_cnt;
    while (accepts < 3 && cyc < 40) begin
      if (req_ready) begin
        sb.push_back('{rd_val ^ addr, 1'b0});
        if (last >= 0) check("accept_gap", cyc - last, 32'd4);
        last = cyc;
        accepts++;
        @(posedge clk);
        @(negedge clk);
        addr = addr + 32'h100;
      end else begin
        @(negedge clk);
      end
      cyc++;
    end
    valid = 1'b0;
    check("accept_count", accepts, 32'd3);
    wait_resp(10);
    repeat (2) @(negedge clk);
    check("b2b_resp_count", resp_cnt - r0, 32'd3);

    // Reset pulse during ACCESS
    wait_req = 10;
    send(32'h4000_0000, 1'b0, 32'd0, 4'h0);
    repeat (2) @(negedge clk);
    check("mid_in_access", {31'd0, apbi.penable}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_bus", {30'd0, apbi.psel, apbi.penable}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mid_ready_after", {31'd0, req_ready}, 32'd1);
    check("mid_no_resp", {31'd0, resp_valid}, 32'd0);
    wait_req = 0; rd_val = 32'h0BAD_F00D;
    sb.push_back('{32'h0BAD_F00D ^ 32'h4000_0008, 1'b0});
    send(32'h4000_000B, 1'b0, 32'd0, 4'h0);
    wait_resp(10);
    @(negedge clk);

`ifdef APB_MST_TIMEOUT_EN
    // Responder never answers: abort after 4 ACCESS cycles
    stuck = 1'b1; pen_cnt = 0;
    sb.push_back('{32'hFFFF_FFFF, 1'b1});
    send(32'h5000_0000, 1'b0, 32'd0, 4'h0);
    wait_resp(20);
    check("tmo_penable_cycles", pen_cnt, 32'd4);
    @(negedge clk);
    check("tmo_idle", {30'd0, req_ready, busy}, 32'd2);
    stuck = 1'b0;
`else
    // Responder stalls: transfer must simply wait
    stuck = 1'b1;
    send(32'h5000_0000, 1'b0, 32'd0, 4'h0);
    repeat (20) @(negedge clk);
    check("stall_still_access", {29'd0, busy, apbi.penable, resp_valid}, 32'd6);
    sb.push_back('{32'h0BAD_F00D ^ 32'h5000_0000, 1'b0});
    stuck = 1'b0;
    wait_resp(5);
    @(negedge clk);
`endif

    repeat (2) @(negedge clk);
    check("sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
